// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hazard_state_e;

  localparam int REG_AW_DEF = 4;
  localparam int CNT_W      = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and stall/flush controls of hazard_ctrl.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  // mem_busy is the data memory's not-ready: while high the whole pipe holds.
  logic              mem_busy;
  logic              cnt_clr;

  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              idex_stall;
  logic              exmem_stall;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_busy, cnt_clr,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
           exmem_stall, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_busy, cnt_clr,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
           exmem_stall, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear winning over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use, taken-branch flush and memory-busy freeze,
// with saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_AW       = REG_AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus,
  output hazard_state_e dbg_state,
  output logic [2:0]    dbg_flush_left
);
  localparam logic [REG_AW-1:0] ZERO_REG   = '0;
  localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  hazard_state_e state_q, state_d;
  logic [2:0]    flush_left_q, flush_left_d;
  logic          load_use;

  assign load_use = bus.ex_memread && (bus.ex_rd != ZERO_REG) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_left_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
    end
  end

  // A busy memory freezes the FSM, so a pending branch is taken up later.
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    if (!bus.mem_busy) begin
      case (state_q)
        RUN: begin
          if (bus.ex_branch_taken && (FLUSH_CYCLES > 1)) begin
            state_d      = FLUSH;
            flush_left_d = FLUSH_INIT;
          end
        end
        FLUSH: begin
          flush_left_d = flush_left_q - 3'd1;
          if (flush_left_q == 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    bus.pc_stall    = 1'b0;
    bus.ifid_stall  = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.idex_stall  = 1'b0;
    bus.exmem_stall = 1'b0;
    if (rst_n) begin
      if (bus.mem_busy) begin
        bus.pc_stall    = 1'b1;
        bus.ifid_stall  = 1'b1;
        bus.idex_stall  = 1'b1;
        bus.exmem_stall = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (bus.ex_branch_taken) begin
              bus.ifid_flush  = 1'b1;
              bus.idex_bubble = 1'b1;
            end else if (load_use) begin
              bus.pc_stall    = 1'b1;
              bus.ifid_stall  = 1'b1;
              bus.idex_bubble = 1'b1;
            end
          end
          FLUSH:   bus.ifid_flush = 1'b1;
          default: bus.ifid_flush = 1'b0;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.pc_stall),
    .clr   (bus.cnt_clr),
    .count (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.ifid_flush),
    .clr   (bus.cnt_clr),
    .count (bus.flush_cycles)
  );

  assign dbg_state      = state_q;
  assign dbg_flush_left = flush_left_q;
endmodule
